// File: rtl/sseg_pkg.sv
// Shared constants for the hex 7-segment driver: segment patterns and anode enables.
// All patterns are active-low, bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry n holds the pattern for hex digit n; the first literal listed is digit F.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   localparam logic [3:0] AN_D0  = 4'b1110;
   localparam logic [3:0] AN_D1  = 4'b1101;
   localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/sseg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module sseg_decoder
   import sseg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/sseg1.sv
// Hex display driver: one nibble of sw[7:0] on digit 0 or 1, all outputs registered.
// Define SSEG1_AUTOSCAN_EN to scan both digits from a free-running counter instead.
module sseg1
   import sseg_pkg::*;
#(
   parameter int REFRESH_BITS = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] sw,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   logic [3:0] an_q,  an_d;
   logic [6:0] seg_q, seg_d;
   logic       dp_q;
   logic       sel;
   logic       blank;
   logic [3:0] nibble;
   logic [6:0] dec_seg;
   logic [6:0] unused_sw;

   assign unused_sw = sw[14:8];

`ifdef SSEG1_AUTOSCAN_EN
   logic [REFRESH_BITS-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_q + 1'b1;
   end

   assign sel   = cnt_q[REFRESH_BITS-1];
   assign blank = sw[15];
`else
   logic [REFRESH_BITS-1:0] unused_cnt;

   assign unused_cnt = '0;
   assign sel        = sw[15];
   assign blank      = 1'b0;
`endif

   assign nibble = sel ? sw[7:4] : sw[3:0];

   sseg_decoder u_dec (
      .hex_i (nibble),
      .seg_o (dec_seg)
   );

   always_comb begin
      an_d  = sel ? AN_D1 : AN_D0;
      seg_d = dec_seg;
      if (blank) begin
         an_d  = AN_OFF;
         seg_d = SEG_BLANK;
      end
   end

   // an and seg share one register stage so a digit never pairs with a stale pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= 1'b1;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_sseg1.sv
// Scoreboard bench for sseg1 (default build): stimulus pushes expected outputs,
// a monitor pops and compares one clock edge later.
module tb_sseg1;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t exp_q[$];

   logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   sseg1 #(.REFRESH_BITS(17)) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw),
      .an  (an),
      .seg (seg),
      .dp  (dp)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic r, input logic [15:0] s);
      exp_t e;
      if (r) begin
         e.an  = 4'b1111;
         e.seg = 7'h7F;
      end else if (s[15]) begin
         e.an  = 4'b1101;
         e.seg = hex_tbl[s[7:4]];
      end else begin
         e.an  = 4'b1110;
         e.seg = hex_tbl[s[3:0]];
      end
      e.dp = 1'b1;
      return e;
   endfunction

   task automatic compare(input string name, input exp_t e);
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
         failures++;
         $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                  name, an, seg, dp, e.an, e.seg, e.dp);
      end else begin
         $display("ok   %s: an=%b seg=%h dp=%b", name, an, seg, dp);
      end
   endtask

   // Monitor: every output update lands on a posedge; compare just after it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) compare("edge", exp_q.pop_front());
      end
   end

   task automatic drive(input logic r, input logic [15:0] s);
      @(negedge clk);
      rst = r;
      sw  = s;
      exp_q.push_back(model(r, s));
   endtask

   // Reset raised between edges must blank the outputs before the next edge.
   task automatic async_reset_pulse();
      exp_t blank_e;
      blank_e = model(1'b1, sw);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 compare("async_rst", blank_e);
      exp_q.push_back(blank_e);
   endtask

   initial begin
      int wait_cycles;
      logic [15:0] s;
      rst = 1'b1;
      sw  = 16'h0000;

      drive(1'b1, 16'h0000);
      drive(0, 16'h0000);
      drive(0, 16'h00AB);
      drive(0, 16'h80AB);
      drive(0, 16'h00CD);
      drive(0, 16'h80CD);
      for (int i = 0; i < 16; i++) drive(0, 16'(i));
      for (int i = 0; i < 8; i++) drive(0, {1'b0, 7'($urandom), 8'h5A});
      for (int i = 0; i < 8; i++) drive(0, {1'b1, 7'($urandom), 8'h5A});

      drive(0, 16'h00AB);
      async_reset_pulse();
      drive(0, 16'h00AB);
      drive(0, 16'h80AB);
      async_reset_pulse();
      drive(0, 16'h80AB);

      for (int i = 0; i < 200; i++) begin
         s = 16'($urandom);
         drive(($urandom_range(0, 19) == 0), s);
      end
      drive(0, 16'hFF3C);

      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
